writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Writeback stage and architectural register file of the LC-3 pipeline. It takes the Execute/MemAccess results (ALU result, memory load data, PC-relative result), selects one per `W_Control`, and writes it into R0–R7. It also answers the Execute stage's `sr1`/`sr2` read requests on `VSR1`/`VSR2`. The `psr` condition codes are updated on every register write.

## Interface
Parameters:
- `DATA_W`, 16, datapath width.
- `NREG`, 8, number of architectural registers; index width is clog2(`NREG`) = 3.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low.
- `enable_writeback`  in  1  qualifies the write for the current cycle.
- `W_Control`  in  2  write source select: 0 `aluout`, 1 `memout`, 2 `pcout`, 3 no write.
- `aluout`  in  16  ALU result from Execute.
- `memout`  in  16  load data from MemAccess.
- `pcout`  in  16  address/PC result from Execute (LEA, JSR link).
- `dr`  in  3  destination register index.
- `sr1`, `sr2`  in  3 each  read indices driven by Execute.
- `VSR1`, `VSR2`  out  16 each  read data for `sr1`/`sr2`.
- `psr`  out  3  condition codes {N,Z,P}.

## Operation
- Write data `wb_data` is a mux of `aluout`, `memout` and `pcout` selected by `W_Control`.
- Write condition: `we` = `enable_writeback` AND `W_Control` != 3.
- When `we` is true, at the rising edge:
  - `R[dr]` <= `wb_data`.
  - `psr` <= 3'b100 if `wb_data`[15] is set; 3'b010 if `wb_data` == 0; 3'b001 otherwise.
- When `we` is false, all registers and `psr` hold their values.
- R0 is an ordinary writable register; there is no hardwired zero.
- Reads are combinational with write-through:
  - `VSR1` = `wb_data` if `we` and `sr1` == `dr`, else `R[sr1]`.
  - `VSR2` follows the same rule with `sr2`.
  - When `sr1` == `sr2` == `dr` with `we` true, both outputs return `wb_data`.
- `W_Control` = 3 is the encoding for stores and branches. It suppresses both the register write and the `psr` update, even when `enable_writeback` = 1.
- No arithmetic is performed; all values pass through at full 16-bit width with no extension.

## Timing
- Reset (`reset` = 0, asynchronous): R0–R7 = 16'h0000 and `psr` = 3'b000, independent of `clock`. `VSR1`/`VSR2` then read 0 combinationally.
- Reset release: the first write can occur on the first rising edge after `reset` returns high.
- Write latency: 1 cycle. A value presented in cycle N is held in `R[dr]` from edge N+1 onward. Through the write-through path it is visible on `VSR1`/`VSR2` already in cycle N.
- `psr` is registered and changes on the same edge as the register write.
- Read path: purely combinational from `sr1`/`sr2`, `dr`, `W_Control`, `enable_writeback` and the data inputs to `VSR1`/`VSR2`, with no added latency.
- Reset asserted mid-cycle while a write is pending: the reset wins and no write occurs.
- Back-to-back writes to the same `dr`: the last write wins, and `psr` reflects the last write.

## Structure
- Shared package `lc3_pkg` holds:
  - `W_Control` encodings: `WB_ALU`=0, `WB_MEM`=1, `WB_PC`=2, `WB_NONE`=3.
  - NZP constants: `NZP_N`=3'b100, `NZP_Z`=3'b010, `NZP_P`=3'b001.
  - `DATA_W` default.
- One sub-module, `reg_file`: `NREG`x`DATA_W` array with one write port and two combinational read ports, including the write-through compare and asynchronous active-low clear.
- The top level holds the source mux, the `we` decode and the `psr` register.

## Test plan
- Assert `reset` low mid-cycle after writing R3 = 16'h1234 -> `VSR1` with `sr1`=3 reads 16'h0000 and `psr` = 3'b000 before the next clock edge.
- Write `aluout`=16'h8000 to R2 with `W_Control`=0, enable=1 -> next cycle R2 = 16'h8000, `psr` = 3'b100. Then write `memout`=0 to R5 with `W_Control`=1 -> `psr` = 3'b010.
- Same cycle: `dr`=4, `sr1`=4, `sr2`=4, `pcout`=16'h3001, `W_Control`=2, enable=1 -> `VSR1` = `VSR2` = 16'h3001 in that cycle, and R4 = 16'h3001 afterwards.
- `W_Control`=3, enable=1, `aluout`=16'h00FF, `dr`=1 -> R1 and `psr` are unchanged.
- enable=0, `W_Control`=0, `aluout`=16'h0007, `dr`=6 -> R6 is unchanged, and `VSR1` with `sr1`=6 shows the old value (no write-through).
- Fill R0–R7 with 16'h0011·i, then read every (`sr1`,`sr2`) pair -> each output equals its register value and R0 holds 16'h0000.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: writeback source encodings, condition-code values
// and the default datapath width.
package lc3_pkg;

    localparam int LC3_DATA_W = 16;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC   = 2'd2,
        WB_NONE = 2'd3
    } wb_sel_e;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

endpackage

// File: rtl/reg_file.sv
// Architectural register array: one write port, two combinational read ports
// that forward the in-flight write data, asynchronous active-low clear.
module reg_file
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W,
    parameter int NREG   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [DATA_W-1:0]       rdata1,
    output logic [DATA_W-1:0]       rdata2
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // A read of the register being written this cycle sees the new value.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
        if (we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// LC-3 writeback stage: selects the result to retire, writes the register
// file and tracks the N/Z/P condition codes.
module writeback_regfile
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W,
    parameter int NREG   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable_writeback,
    input  logic [1:0]              W_Control,
    input  logic [DATA_W-1:0]       aluout,
    input  logic [DATA_W-1:0]       memout,
    input  logic [DATA_W-1:0]       pcout,
    input  logic [$clog2(NREG)-1:0] dr,
    input  logic [$clog2(NREG)-1:0] sr1,
    input  logic [$clog2(NREG)-1:0] sr2,
    output logic [DATA_W-1:0]       VSR1,
    output logic [DATA_W-1:0]       VSR2,
    output logic [2:0]              psr
);

    logic [DATA_W-1:0] wb_data;
    logic              we;

    always_comb begin
        wb_data = '0;
        case (W_Control)
            WB_ALU:  wb_data = aluout;
            WB_MEM:  wb_data = memout;
            WB_PC:   wb_data = pcout;
            default: wb_data = '0;
        endcase
    end

    // Stores and branches use WB_NONE, which blocks both the write and the CC update.
    assign we = enable_writeback && (W_Control != WB_NONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            psr <= 3'b000;
        end else if (we) begin
            if (wb_data[DATA_W-1]) begin
                psr <= NZP_N;
            end else if (wb_data == '0) begin
                psr <= NZP_Z;
            end else begin
                psr <= NZP_P;
            end
        end
    end

    reg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .clock  (clock),
        .reset  (reset),
        .we     (we),
        .waddr  (dr),
        .wdata  (wb_data),
        .raddr1 (sr1),
        .raddr2 (sr2),
        .rdata1 (VSR1),
        .rdata2 (VSR2)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_writeback_regfile;

    logic        clock;
    logic        reset;
    logic        enable_writeback;
    logic [1:0]  W_Control;
    logic [15:0] aluout;
    logic [15:0] memout;
    logic [15:0] pcout;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic [2:0]  psr;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] exp_v1_q [$];
    logic [15:0] exp_v2_q [$];
    logic [2:0]  exp_psr_q [$];
    string       exp_name_q [$];

    writeback_regfile #(
        .DATA_W (16),
        .NREG   (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_writeback (enable_writeback),
        .W_Control        (W_Control),
        .aluout           (aluout),
        .memout           (memout),
        .pcout            (pcout),
        .dr               (dr),
        .sr1              (sr1),
        .sr2              (sr2),
        .VSR1             (VSR1),
        .VSR2             (VSR2),
        .psr              (psr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input string field,
                               input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s got %h expected %h", name, field, got, want);
        end
    endtask

    // Monitor: one queued expectation is consumed per falling edge.
    always @(negedge clock) begin
        if (exp_v1_q.size() > 0) begin
            string       n;
            logic [15:0] e1;
            logic [15:0] e2;
            logic [2:0]  ep;
            n  = exp_name_q.pop_front();
            e1 = exp_v1_q.pop_front();
            e2 = exp_v2_q.pop_front();
            ep = exp_psr_q.pop_front();
            checkOutput(n, "VSR1", VSR1, e1);
            checkOutput(n, "VSR2", VSR2, e2);
            checkOutput(n, "psr", {13'd0, psr}, {13'd0, ep});
        end
    end

    // Drives one cycle of inputs shortly after the rising edge and queues the
    // outputs expected while those inputs are applied.
    task automatic applyStimulus(input string name, input logic rst_n,
                                 input logic en, input logic [1:0] wc,
                                 input logic [15:0] alu, input logic [15:0] mem,
                                 input logic [15:0] pc, input logic [2:0] d,
                                 input logic [2:0] s1, input logic [2:0] s2,
                                 input logic [15:0] e1, input logic [15:0] e2,
                                 input logic [2:0] ep);
        @(posedge clock);
        #1;
        reset            = rst_n;
        enable_writeback = en;
        W_Control        = wc;
        aluout           = alu;
        memout           = mem;
        pcout            = pc;
        dr               = d;
        sr1              = s1;
        sr2              = s2;
        exp_name_q.push_back(name);
        exp_v1_q.push_back(e1);
        exp_v2_q.push_back(e2);
        exp_psr_q.push_back(ep);
    endtask

    initial begin
        reset            = 1'b0;
        enable_writeback = 1'b0;
        W_Control        = 2'd0;
        aluout           = '0;
        memout           = '0;
        pcout            = '0;
        dr               = '0;
        sr1              = '0;
        sr2              = '0;

        applyStimulus("in_reset",   1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd7, 16'h0000, 16'h0000, 3'b000);
        applyStimulus("wr_r3",      1'b1, 1'b1, 2'd0, 16'h1234, 16'h0000, 16'h0000, 3'd3, 3'd3, 3'd0, 16'h1234, 16'h0000, 3'b000);
        applyStimulus("rd_r3",      1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd3, 3'd3, 16'h1234, 16'h1234, 3'b001);
        applyStimulus("mid_reset",  1'b0, 1'b1, 2'd0, 16'h5555, 16'h0000, 16'h0000, 3'd5, 3'd3, 3'd0, 16'h0000, 16'h0000, 3'b000);
        applyStimulus("hold_reset", 1'b0, 1'b1, 2'd0, 16'h5555, 16'h0000, 16'h0000, 3'd5, 3'd3, 3'd0, 16'h0000, 16'h0000, 3'b000);
        applyStimulus("released",   1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd5, 3'd3, 16'h0000, 16'h0000, 3'b000);
        applyStimulus("wr_r2_alu",  1'b1, 1'b1, 2'd0, 16'h8000, 16'h0000, 16'h0000, 3'd2, 3'd2, 3'd1, 16'h8000, 16'h0000, 3'b000);
        applyStimulus("wr_r5_mem",  1'b1, 1'b1, 2'd1, 16'hFFFF, 16'h0000, 16'h0000, 3'd5, 3'd2, 3'd5, 16'h8000, 16'h0000, 3'b100);
        applyStimulus("wt_r4_pc",   1'b1, 1'b1, 2'd2, 16'h1111, 16'h2222, 16'h3001, 3'd4, 3'd4, 3'd4, 16'h3001, 16'h3001, 3'b010);
        applyStimulus("rd_r4",      1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd4, 3'd2, 16'h3001, 16'h8000, 3'b001);
        applyStimulus("wr_r1",      1'b1, 1'b1, 2'd0, 16'h8042, 16'h0000, 16'h0000, 3'd1, 3'd1, 3'd0, 16'h8042, 16'h0000, 3'b001);
        applyStimulus("none_r1",    1'b1, 1'b1, 2'd3, 16'h00FF, 16'h00FF, 16'h00FF, 3'd1, 3'd1, 3'd1, 16'h8042, 16'h8042, 3'b100);
        applyStimulus("rd_r1",      1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd1, 3'd4, 16'h8042, 16'h3001, 3'b100);
        applyStimulus("wr_r6",      1'b1, 1'b1, 2'd0, 16'h0600, 16'h0000, 16'h0000, 3'd6, 3'd6, 3'd6, 16'h0600, 16'h0600, 3'b100);
        applyStimulus("dis_r6",     1'b1, 1'b0, 2'd0, 16'h0007, 16'h0000, 16'h0000, 3'd6, 3'd6, 3'd2, 16'h0600, 16'h8000, 3'b001);
        applyStimulus("rd_r6",      1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd6, 3'd6, 16'h0600, 16'h0600, 3'b001);

        // Fill R0..R7 with 0x11*i; R0 receives zero, so psr goes Z then P.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            logic [2:0]  ep;
            v  = 16'(16'h0011 * i);
            ep = (i == 1) ? 3'b010 : 3'b001;
            applyStimulus("fill", 1'b1, 1'b1, 2'd0, v, 16'h0000, 16'h0000, 3'(i), 3'(i), 3'(i), v, v, ep);
        end

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus("pair", 1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'(a), 3'(b),
                              16'(16'h0011 * a), 16'(16'h0011 * b), 3'b001);
            end
        end

        repeat (3) @(posedge clock);
        if (exp_v1_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain pending %0d expected 0", exp_v1_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
